// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM of the multicycle MIPS datapath. Every clock it steps one
// phase of the current instruction (fetch, decode, execute, memory,
// write-back) and raises the datapath enables and selects for that phase.
// Opcode and Funct come from the externally held instruction register and
// must stay stable from the FETCH edge to the end of the instruction.
//
// Ports:
//   CLK       in  1  system clock, rising edge
//   RST_N     in  1  asynchronous active-low reset (forces State=FETCH)
//   Opcode    in  6  IR[31:26]
//   Funct     in  6  IR[5:0]
//   Zero      in  1  ALU zero flag (used by beq/bne)
//   PCWrite   out 1  PC load enable
//   IorD      out 1  memory address select: 0 PC, 1 ALUOut
//   MemRead   out 1  memory read strobe
//   MemWrite  out 1  memory write strobe
//   IRWrite   out 1  IR load enable
//   RegDst    out 2  write register: 0 rt, 1 rd, 2 r31
//   MemtoReg  out 2  write data: 0 ALUOut, 1 MDR, 2 PC
//   RegWrite  out 1  register file write enable
//   ALUSrcA   out 2  SrcA: 0 PC, 1 A, 2 zero-extended shamt
//   ALUSrcB   out 2  SrcB: 0 B, 1 const 4, 2 immext, 3 signext(imm)<<2
//   ZeroExt   out 1  immext is zero-extended when 1
//   ALUOp     out 6  ALU operation (ALUOP_* codes)
//   PCSource  out 2  next PC: 0 ALU result, 1 ALUOut, 2 jump target, 3 A
//   Illegal   out 1  one-cycle pulse in DECODE on an undecodable instruction
//   State     out 4  current state, for debug
//
// Optional feature macro: CTRL_JAL_JR_EN
//   Defined: jal and jr are decoded and executed through the JUMP state
//   (jal also writes PC+4 to r31, jr loads the PC from register A).
//   Undefined: jal and jr are treated as illegal instructions.
// ---------------------------------------------------------------------------

// ALU operation codes. Normally supplied by aluop_def.v; these defaults keep
// the file self-contained and give way to any earlier definition.
`ifndef ALUOP_ADD
`define ALUOP_ADD  6'd0
`endif
`ifndef ALUOP_ADDU
`define ALUOP_ADDU 6'd1
`endif
`ifndef ALUOP_SUB
`define ALUOP_SUB  6'd2
`endif
`ifndef ALUOP_SUBU
`define ALUOP_SUBU 6'd3
`endif
`ifndef ALUOP_AND
`define ALUOP_AND  6'd4
`endif
`ifndef ALUOP_OR
`define ALUOP_OR   6'd5
`endif
`ifndef ALUOP_XOR
`define ALUOP_XOR  6'd6
`endif
`ifndef ALUOP_NOR
`define ALUOP_NOR  6'd7
`endif
`ifndef ALUOP_SLT
`define ALUOP_SLT  6'd8
`endif
`ifndef ALUOP_SLTU
`define ALUOP_SLTU 6'd9
`endif
`ifndef ALUOP_SLL
`define ALUOP_SLL  6'd10
`endif
`ifndef ALUOP_SRL
`define ALUOP_SRL  6'd11
`endif
`ifndef ALUOP_SRA
`define ALUOP_SRA  6'd12
`endif
`ifndef ALUOP_SLLV
`define ALUOP_SLLV 6'd13
`endif
`ifndef ALUOP_SRLV
`define ALUOP_SRLV 6'd14
`endif
`ifndef ALUOP_SRAV
`define ALUOP_SRAV 6'd15
`endif
`ifndef ALUOP_LUI
`define ALUOP_LUI  6'd16
`endif

module multicycle_ctrl (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic [5:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_IEXE   = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state;
  state_t next_state;

  logic       is_mem;
  logic       is_rtype;
  logic       rt_known;
  logic       rt_shamt;
  logic [5:0] rt_alu_op;
  logic       is_itype;
  logic       i_zero_ext;
  logic [5:0] i_alu_op;
  logic       is_branch;
  logic       is_jal;
  logic       is_jr;
  logic       is_jump;
  logic       decodable;

  assign State = state;

  // Instruction decode shared by next-state and output logic. R-type funct
  // and I-type opcode are translated to ALU codes here so the FSM only has
  // to pick which translation applies in the current state.
  always_comb begin
    rt_known   = 1'b1;
    rt_shamt   = 1'b0;
    rt_alu_op  = `ALUOP_ADDU;
    case (Funct)
      6'b100000: rt_alu_op = `ALUOP_ADD;
      6'b100001: rt_alu_op = `ALUOP_ADDU;
      6'b100010: rt_alu_op = `ALUOP_SUB;
      6'b100011: rt_alu_op = `ALUOP_SUBU;
      6'b100100: rt_alu_op = `ALUOP_AND;
      6'b100101: rt_alu_op = `ALUOP_OR;
      6'b100110: rt_alu_op = `ALUOP_XOR;
      6'b100111: rt_alu_op = `ALUOP_NOR;
      6'b101010: rt_alu_op = `ALUOP_SLT;
      6'b101011: rt_alu_op = `ALUOP_SLTU;
      6'b000100: rt_alu_op = `ALUOP_SLLV;
      6'b000110: rt_alu_op = `ALUOP_SRLV;
      6'b000111: rt_alu_op = `ALUOP_SRAV;
      6'b000000: begin rt_alu_op = `ALUOP_SLL; rt_shamt = 1'b1; end
      6'b000010: begin rt_alu_op = `ALUOP_SRL; rt_shamt = 1'b1; end
      6'b000011: begin rt_alu_op = `ALUOP_SRA; rt_shamt = 1'b1; end
      default:   rt_known = 1'b0;
    endcase

    is_itype   = 1'b1;
    i_zero_ext = 1'b0;
    i_alu_op   = `ALUOP_ADDU;
    case (Opcode)
      6'b001000: i_alu_op = `ALUOP_ADD;
      6'b001001: i_alu_op = `ALUOP_ADDU;
      6'b001010: i_alu_op = `ALUOP_SLT;
      6'b001011: i_alu_op = `ALUOP_SLTU;
      6'b001100: begin i_alu_op = `ALUOP_AND; i_zero_ext = 1'b1; end
      6'b001101: begin i_alu_op = `ALUOP_OR;  i_zero_ext = 1'b1; end
      6'b001110: begin i_alu_op = `ALUOP_XOR; i_zero_ext = 1'b1; end
      6'b001111: i_alu_op = `ALUOP_LUI;
      default:   is_itype = 1'b0;
    endcase
  end

  assign is_mem    = (Opcode == OP_LW) || (Opcode == OP_SW);
  assign is_rtype  = (Opcode == OP_RTYPE);
  assign is_branch = (Opcode == OP_BEQ) || (Opcode == OP_BNE);

`ifdef CTRL_JAL_JR_EN
  assign is_jal = (Opcode == OP_JAL);
  assign is_jr  = is_rtype && (Funct == FN_JR);
`else
  assign is_jal = 1'b0;
  assign is_jr  = 1'b0;
`endif

  assign is_jump   = (Opcode == OP_J) || is_jal || is_jr;
  assign decodable = is_mem || (is_rtype && rt_known) || is_itype ||
                     is_branch || is_jump;

  // State register; reset drops straight back to FETCH with no hold-off, so
  // any write enable of an interrupted instruction falls immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Only DECODE and MEMADR branch on the instruction;
  // every terminal phase returns to FETCH.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (is_mem)                     next_state = S_MEMADR;
        else if (is_rtype && rt_known)  next_state = S_RTEXE;
        else if (is_itype)              next_state = S_IEXE;
        else if (is_branch)             next_state = S_BRANCH;
        else if (is_jump)               next_state = S_JUMP;
        else                            next_state = S_FETCH;
      end
      S_MEMADR: next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_state = S_MEMWB;
      S_RTEXE:  next_state = S_RTWB;
      S_IEXE:   next_state = S_IWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // Output decode. Mostly Moore; the input-dependent exceptions are the
  // ALU controls in the execute states, the branch PC write, the jump
  // variants and the illegal pulse in DECODE.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 2'd0;
    MemtoReg = 2'd0;
    RegWrite = 1'b0;
    ALUSrcA  = 2'd0;
    ALUSrcB  = 2'd0;
    ZeroExt  = 1'b0;
    ALUOp    = `ALUOP_ADDU;
    PCSource = 2'd0;
    Illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        Illegal = ~decodable;
      end
      S_MEMADR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTEXE: begin
        ALUSrcA = rt_shamt ? 2'd2 : 2'd1;
        ALUOp   = rt_alu_op;
      end
      S_RTWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'd1;
      end
      S_IEXE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        ALUOp   = i_alu_op;
        ZeroExt = i_zero_ext;
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 2'd1;
        ALUOp    = `ALUOP_SUBU;
        PCSource = 2'd1;
        PCWrite  = (Opcode == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = is_jr ? 2'd3 : 2'd2;
        if (is_jal) begin
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd2;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each instruction pushes the expected
// per-cycle output vectors onto a scoreboard queue; the vectors are then
// popped one per clock and compared against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_ADDU = 6'd1;
  localparam logic [5:0] OP_SUBU = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_LUI  = 6'd16;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       zero_ext;
    logic [5:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    string tag;
    outs_t v;
  } exp_t;

  logic       CLK;
  logic       RST_N;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic       ZeroExt, Illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [5:0] ALUOp;
  logic [3:0] State;

  outs_t obs;
  exp_t  sb[$];
  int    n_cmp;
  int    n_fail;

  multicycle_ctrl dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Opcode   (Opcode),
    .Funct    (Funct),
    .Zero     (Zero),
    .PCWrite  (PCWrite),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ZeroExt  (ZeroExt),
    .ALUOp    (ALUOp),
    .PCSource (PCSource),
    .Illegal  (Illegal),
    .State    (State)
  );

  assign obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ZeroExt, ALUOp, PCSource,
                Illegal, State};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Quiet vector: everything 0, ALUOp at its ADDU default.
  function automatic outs_t base(input logic [3:0] st);
    outs_t o;
    o        = '0;
    o.alu_op = OP_ADDU;
    o.state  = st;
    return o;
  endfunction

  function automatic outs_t fetch_v();
    outs_t o;
    o          = base(4'd0);
    o.mem_read = 1'b1;
    o.ir_write = 1'b1;
    o.src_b    = 2'd1;
    o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic outs_t decode_v(input logic ill);
    outs_t o;
    o         = base(4'd1);
    o.src_b   = 2'd3;
    o.illegal = ill;
    return o;
  endfunction

  task automatic push(input string tag, input outs_t v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  // Pop one expectation and compare it with the current DUT outputs.
  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
  endtask

  // Called on a falling edge; checks one queued vector per clock.
  task automatic run_queue();
    while (sb.size() > 0) begin
      #1;
      check_output();
      @(negedge CLK);
    end
  endtask

  // Drives the instruction fields and queues the FETCH and DECODE vectors.
  task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic ill);
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    push("fetch", fetch_v());
    push("decode", decode_v(ill));
  endtask

  initial begin
    outs_t v;
    n_cmp  = 0;
    n_fail = 0;
    RST_N  = 1'b0;
    Opcode = 6'd0;
    Funct  = 6'd0;
    Zero   = 1'b0;

    // Reset state: FETCH outputs while held in reset.
    #3;
    push("reset", fetch_v());
    check_output();
    @(negedge CLK);
    RST_N = 1'b1;

    // lw: 0,1,2,3,4
    apply_stimulus(6'b100011, 6'd0, 1'b0, 1'b0);
    v = base(4'd2); v.src_a = 2'd1; v.src_b = 2'd2;        push("lw_memadr", v);
    v = base(4'd3); v.mem_read = 1'b1; v.iord = 1'b1;      push("lw_memrd", v);
    v = base(4'd4); v.reg_write = 1'b1; v.mem_to_reg = 2'd1; push("lw_memwb", v);
    run_queue();

    // subu
    apply_stimulus(6'b000000, 6'b100011, 1'b0, 1'b0);
    v = base(4'd6); v.src_a = 2'd1; v.alu_op = OP_SUBU;    push("subu_exe", v);
    v = base(4'd7); v.reg_write = 1'b1; v.reg_dst = 2'd1;  push("subu_wb", v);
    run_queue();

    // sll uses the shamt operand
    apply_stimulus(6'b000000, 6'b000000, 1'b0, 1'b0);
    v = base(4'd6); v.src_a = 2'd2; v.alu_op = OP_SLL;     push("sll_exe", v);
    v = base(4'd7); v.reg_write = 1'b1; v.reg_dst = 2'd1;  push("sll_wb", v);
    run_queue();

    // ori zero-extends
    apply_stimulus(6'b001101, 6'b010101, 1'b0, 1'b0);
    v = base(4'd8); v.src_a = 2'd1; v.src_b = 2'd2; v.zero_ext = 1'b1; v.alu_op = OP_OR;
    push("ori_exe", v);
    v = base(4'd9); v.reg_write = 1'b1;                    push("ori_wb", v);
    run_queue();

    // lui
    apply_stimulus(6'b001111, 6'd0, 1'b0, 1'b0);
    v = base(4'd8); v.src_a = 2'd1; v.src_b = 2'd2; v.alu_op = OP_LUI;
    push("lui_exe", v);
    v = base(4'd9); v.reg_write = 1'b1;                    push("lui_wb", v);
    run_queue();

    // beq / bne with both Zero values
    for (int k = 0; k < 4; k++) begin
      logic is_bne;
      logic z;
      is_bne = k[1];
      z      = k[0];
      apply_stimulus(is_bne ? 6'b000101 : 6'b000100, 6'd0, z, 1'b0);
      v = base(4'd10); v.src_a = 2'd1; v.alu_op = OP_SUBU; v.pc_source = 2'd1;
      v.pc_write = is_bne ? !z : z;
      push(is_bne ? (z ? "bne_z1" : "bne_z0") : (z ? "beq_z1" : "beq_z0"), v);
      run_queue();
    end

    // j
    apply_stimulus(6'b000010, 6'd0, 1'b0, 1'b0);
    v = base(4'd11); v.pc_write = 1'b1; v.pc_source = 2'd2; push("j_jump", v);
    run_queue();

    // undecodable opcode and unknown R-type funct
    apply_stimulus(6'b111111, 6'd0, 1'b0, 1'b1);
    run_queue();
    apply_stimulus(6'b000000, 6'b000001, 1'b0, 1'b1);
    run_queue();

`ifdef CTRL_JAL_JR_EN
    apply_stimulus(6'b000011, 6'd0, 1'b0, 1'b0);
    v = base(4'd11); v.pc_write = 1'b1; v.pc_source = 2'd2;
    v.reg_write = 1'b1; v.reg_dst = 2'd2; v.mem_to_reg = 2'd2;
    push("jal_jump", v);
    run_queue();
    apply_stimulus(6'b000000, 6'b001000, 1'b0, 1'b0);
    v = base(4'd11); v.pc_write = 1'b1; v.pc_source = 2'd3; push("jr_jump", v);
    run_queue();
`else
    apply_stimulus(6'b000011, 6'd0, 1'b0, 1'b1);
    run_queue();
    apply_stimulus(6'b000000, 6'b001000, 1'b0, 1'b1);
    run_queue();
`endif

    // sw interrupted by reset while in MEMWR
    apply_stimulus(6'b101011, 6'd0, 1'b0, 1'b0);
    v = base(4'd2); v.src_a = 2'd1; v.src_b = 2'd2;        push("sw_memadr", v);
    run_queue();
    v = base(4'd5); v.mem_write = 1'b1; v.iord = 1'b1;     push("sw_memwr", v);
    #1;
    check_output();
    #2;
    RST_N = 1'b0;
    push("sw_reset", fetch_v());
    #1;
    check_output();
    @(negedge CLK);
    RST_N = 1'b1;

    // recovery after reset: a fresh addiu runs normally
    apply_stimulus(6'b001001, 6'd0, 1'b0, 1'b0);
    v = base(4'd8); v.src_a = 2'd1; v.src_b = 2'd2;        push("addiu_exe", v);
    v = base(4'd9); v.reg_write = 1'b1;                    push("addiu_wb", v);
    push("final_fetch", fetch_v());
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
